// File: rtl/comporta_fd.sv
// Gate datapath: bounded auto-reversing position counter, step interval timer and servo PWM.
// Define COMPORTA_FD_DEBUG_EN to expose position, direction and timer on debug ports.
module comporta_fd #(
    parameter int N_POS           = 8,
    parameter int INTERVAL_CYCLES = 25_000_000,
    parameter int PWM_PERIOD      = 1_000_000,
    parameter int PULSE_MIN       = 50_000,
    parameter int PULSE_STEP      = 7_000,
    localparam int PW = $clog2(N_POS),
    localparam int TW = $clog2(INTERVAL_CYCLES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          zeraUpdown,
    input  logic          zeraIntervalo,
    input  logic          contaUpdown,
    input  logic          contaIntervalo,
    output logic          inicioPosicao,
    output logic          fimPosicao,
    output logic          fimContadorIntervalo,
`ifdef COMPORTA_FD_DEBUG_EN
    output logic          pwm,
    output logic [PW-1:0] dbPosicao,
    output logic [0:0]    dbSentido,
    output logic [TW-1:0] dbIntervalo
`else
    output logic          pwm
`endif
);

    localparam int AW = $clog2(PWM_PERIOD);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } sentido_t;

    logic [PW-1:0] posicao;
    sentido_t      sentido;
    logic [TW-1:0] intervalo;
    logic [AW-1:0] frameCnt;
    logic [AW-1:0] largura;
    logic [AW-1:0] larguraNext;

    assign inicioPosicao        = (posicao == '0);
    assign fimPosicao           = (posicao == PW'(N_POS - 1));
    assign fimContadorIntervalo = (intervalo == TW'(INTERVAL_CYCLES - 1));

    // Bounds take precedence over the stored direction so the counter never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            posicao <= '0;
            sentido <= UP;
        end else if (zeraUpdown) begin
            posicao <= '0;
            sentido <= UP;
        end else if (contaUpdown) begin
            if (fimPosicao) begin
                posicao <= posicao - PW'(1);
                sentido <= DOWN;
            end else if (inicioPosicao) begin
                posicao <= posicao + PW'(1);
                sentido <= UP;
            end else if (sentido == UP) begin
                posicao <= posicao + PW'(1);
            end else begin
                posicao <= posicao - PW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            intervalo <= '0;
        end else if (zeraIntervalo || contaUpdown) begin
            intervalo <= '0;
        end else if (contaIntervalo) begin
            if (fimContadorIntervalo) begin
                intervalo <= '0;
            end else begin
                intervalo <= intervalo + TW'(1);
            end
        end
    end

    always_comb begin
        larguraNext = AW'(PULSE_MIN) + AW'(posicao) * AW'(PULSE_STEP);
    end

    // Width is only sampled on the last frame cycle, so a move never alters the frame in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frameCnt <= '0;
            largura  <= AW'(PULSE_MIN);
            pwm      <= 1'b0;
        end else begin
            pwm <= (frameCnt < largura);
            if (frameCnt == AW'(PWM_PERIOD - 1)) begin
                frameCnt <= '0;
                largura  <= larguraNext;
            end else begin
                frameCnt <= frameCnt + AW'(1);
            end
        end
    end

`ifdef COMPORTA_FD_DEBUG_EN
    assign dbPosicao   = posicao;
    assign dbSentido   = sentido;
    assign dbIntervalo = intervalo;
`endif

endmodule

// File: tb/tb_comporta_fd.sv
// Directed self-checking bench for comporta_fd with small parameters (4 positions, 5-cycle interval, 20-cycle frame).
module tb_comporta_fd;

    logic clock = 1'b0;
    logic reset;
    logic zeraUpdown, zeraIntervalo, contaUpdown, contaIntervalo;
    logic inicioPosicao, fimPosicao, fimContadorIntervalo, pwm;

    int checks = 0;
    int errors = 0;
    int highs;
    int found;
    logic prev;

    comporta_fd #(
        .N_POS(4),
        .INTERVAL_CYCLES(5),
        .PWM_PERIOD(20),
        .PULSE_MIN(2),
        .PULSE_STEP(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .zeraUpdown(zeraUpdown),
        .zeraIntervalo(zeraIntervalo),
        .contaUpdown(contaUpdown),
        .contaIntervalo(contaIntervalo),
        .inicioPosicao(inicioPosicao),
        .fimPosicao(fimPosicao),
        .fimContadorIntervalo(fimContadorIntervalo),
        .pwm(pwm)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hold inputs long enough for the new width to be latched, then count one full frame.
    task automatic measure(output int h);
        repeat (21) step();
        h = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            h += int'(pwm);
        end
    endtask

    initial begin
        reset = 1'b1;
        zeraUpdown = 1'b0; zeraIntervalo = 1'b0; contaUpdown = 1'b0; contaIntervalo = 1'b0;
        repeat (3) step();
        check("rst_inicio", inicioPosicao, 1);
        check("rst_fim", fimPosicao, 0);
        check("rst_fimInt", fimContadorIntervalo, 0);
        check("rst_pwm", pwm, 0);
        reset = 1'b0;

        // Move away from the reset state, then reset asynchronously mid-cycle.
        contaUpdown = 1'b1; step(); step();
        contaUpdown = 1'b0; contaIntervalo = 1'b1; step(); step();
        check("pre_rst_inicio", inicioPosicao, 0);
        #3 reset = 1'b1;
        #1;
        check("async_rst_inicio", inicioPosicao, 1);
        check("async_rst_fimInt", fimContadorIntervalo, 0);
        check("async_rst_pwm", pwm, 0);
        step(); step();
        check("rst_held_pwm", pwm, 0);
        check("rst_held_inicio", inicioPosicao, 1);
        reset = 1'b0; contaIntervalo = 1'b0;

        // Open sweep: 0 -> 3, then reverse.
        zeraUpdown = 1'b1; step(); zeraUpdown = 1'b0;
        check("zera_inicio", inicioPosicao, 1);
        contaUpdown = 1'b1;
        step(); check("pos1_inicio", inicioPosicao, 0); check("pos1_fim", fimPosicao, 0);
        step(); check("pos2_fim", fimPosicao, 0);
        step(); check("pos3_fim", fimPosicao, 1);
        step(); contaUpdown = 1'b0;
        check("rev_pos2_fim", fimPosicao, 0);
        check("rev_pos2_inicio", inicioPosicao, 0);
        measure(highs);
        check("pwm_pos2", highs, 8);

        // Close sweep: 2 -> 1 -> 0, then bounce up.
        contaUpdown = 1'b1;
        step(); check("down_pos1_inicio", inicioPosicao, 0);
        step(); check("down_pos0_inicio", inicioPosicao, 1);
        step(); check("bounce_pos1_inicio", inicioPosicao, 0);
        step(); check("up_pos2_fim", fimPosicao, 0);
        step(); check("up_pos3_fim", fimPosicao, 1);
        contaUpdown = 1'b0;

        // Interval timer auto-restart.
        zeraIntervalo = 1'b1; step(); zeraIntervalo = 1'b0;
        check("tmr_clear", fimContadorIntervalo, 0);
        contaIntervalo = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("tmr_edge%0d", k), fimContadorIntervalo, (k % 5 == 4) ? 1 : 0);
        end

        // A step restarts the interval.
        zeraIntervalo = 1'b1; step(); zeraIntervalo = 1'b0;
        step(); step(); step();
        contaUpdown = 1'b1; step(); contaUpdown = 1'b0;
        check("tmr_step_clear", fimContadorIntervalo, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("tmr_after_step%0d", k), fimContadorIntervalo, (k == 4) ? 1 : 0);
        end
        contaIntervalo = 1'b0;

        // zeraUpdown beats contaUpdown.
        zeraUpdown = 1'b1; step(); zeraUpdown = 1'b0;
        contaUpdown = 1'b1; step(); step();
        check("prio_pre_inicio", inicioPosicao, 0);
        zeraUpdown = 1'b1; step(); zeraUpdown = 1'b0;
        check("prio_inicio", inicioPosicao, 1);
        step(); check("prio_pos1_inicio", inicioPosicao, 0);
        step(); check("prio_pos2_fim", fimPosicao, 0);
        step(); check("prio_pos3_fim", fimPosicao, 1);
        contaUpdown = 1'b0;

        measure(highs);
        check("pwm_pos3", highs, 11);

        // Align to a frame start, move to pos 0 mid-frame: current frame keeps 11, next has 2.
        found = 0;
        prev = pwm;
        for (int i = 0; i < 60 && found == 0; i++) begin
            step();
            if (prev == 1'b0 && pwm == 1'b1) found = 1;
            else prev = pwm;
        end
        check("frame_sync", found, 1);
        highs = 1;
        for (int i = 1; i < 20; i++) begin
            if (i == 3) zeraUpdown = 1'b1;
            step();
            zeraUpdown = 1'b0;
            highs += int'(pwm);
        end
        check("pwm_midframe_hold", highs, 11);
        check("midframe_inicio", inicioPosicao, 1);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            highs += int'(pwm);
        end
        check("pwm_next_frame_pos0", highs, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
